// File: rtl/avalon_io_pkg.sv
// Shared types and elaboration-time helpers for the Avalon pin-side I/O unit.
// Holds the TX state encoding, the counter-width helper and the width legality check.
package avalon_io_pkg;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    // A single-beat word still needs a 1-bit counter so the port widths stay legal
    function automatic int cnt_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    function automatic bit widths_legal(input int pin_w, input int word_w, input int out_w);
        return (pin_w > 0) && (out_w > 0) && (word_w > 0) &&
               ((word_w % pin_w) == 0) && ((word_w % out_w) == 0);
    endfunction

endpackage

// File: rtl/avalon_ef_sync.sv
// One external-flag lane: 2-flop synchroniser, a third flop for edge detection,
// and a sticky rising-edge bit cleared by ef_clr (a simultaneous new edge wins).
module avalon_ef_sync (
    input  logic CLK,
    input  logic RST,
    input  logic ef_in,
    input  logic ef_clr,
    output logic ef_level,
    output logic ef_rise
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            sync_3  <= 1'b0;
            ef_rise <= 1'b0;
        end else begin
            sync_1  <= ef_in;
            sync_2  <= sync_1;
            sync_3  <= sync_2;
            ef_rise <= (sync_2 & ~sync_3) | (ef_rise & ~ef_clr);
        end
    end

    assign ef_level = sync_2;

endmodule

// File: rtl/avalon_pin_io.sv
// Pin-side I/O unit: beat-serial RX deserialiser with a one-word holding register,
// beat-serial TX serialiser and NUM_EF synchronised external flags with sticky edge capture.
module avalon_pin_io
    import avalon_io_pkg::*;
#(
    parameter int PIN_W  = 4,
    parameter int WORD_W = 8,
    parameter int OUT_W  = 4,
    parameter int NUM_EF = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [PIN_W-1:0]  pin_in,
    input  logic              pin_strobe,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic              ovr_clr,
    input  logic [WORD_W-1:0] tx_word,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [OUT_W-1:0]  pin_out,
    output logic              pin_out_valid,
    input  logic [NUM_EF-1:0] ef_in,
    output logic [NUM_EF-1:0] ef_level,
    output logic [NUM_EF-1:0] ef_rise,
    input  logic [NUM_EF-1:0] ef_clr
);

    localparam int RX_BEATS = WORD_W / PIN_W;
    localparam int TX_BEATS = WORD_W / OUT_W;
    localparam int RX_CW    = cnt_width(RX_BEATS);
    localparam int TX_CW    = cnt_width(TX_BEATS);

    if (!widths_legal(PIN_W, WORD_W, OUT_W)) begin : g_width_check
        $error("avalon_pin_io: WORD_W must be a multiple of both PIN_W and OUT_W");
    end

    logic [RX_CW-1:0]  rx_beat;
    logic [WORD_W-1:0] rx_asm;
    logic [WORD_W-1:0] rx_asm_next;
    logic              rx_last;
    logic              rx_complete;
    logic              rx_take;

    // The completing beat is merged combinationally so the holder can load the full word in the same edge
    always_comb begin
        rx_asm_next = rx_asm;
        rx_asm_next[int'(rx_beat)*PIN_W +: PIN_W] = pin_in;
        rx_last     = (rx_beat == RX_CW'(RX_BEATS - 1));
        rx_complete = pin_strobe && rx_last;
        rx_take     = rx_valid && rx_ready;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_beat    <= '0;
            rx_asm     <= '0;
            rx_word    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (pin_strobe) begin
                rx_asm  <= rx_asm_next;
                rx_beat <= rx_last ? '0 : rx_beat + RX_CW'(1);
            end
            if (rx_complete && (!rx_valid || rx_ready)) begin
                rx_word  <= rx_asm_next;
                rx_valid <= 1'b1;
            end else if (rx_take) begin
                rx_valid <= 1'b0;
            end
            if (rx_complete && rx_valid && !rx_ready) begin
                rx_overrun <= 1'b1;
            end else if (ovr_clr) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    tx_state_t         tx_state;
    tx_state_t         tx_state_next;
    logic [WORD_W-1:0] tx_shift;
    logic [TX_CW-1:0]  tx_beat;
    logic [TX_CW-1:0]  tx_beat_next;
    logic              tx_load;
    logic              tx_last;

    // Offering tx_ready on the last beat lets back-to-back words stream without an idle gap
    always_comb begin
        tx_state_next = tx_state;
        tx_beat_next  = tx_beat;
        tx_load       = 1'b0;
        tx_ready      = 1'b0;
        pin_out       = '0;
        pin_out_valid = 1'b0;
        tx_last       = (tx_beat == TX_CW'(TX_BEATS - 1));
        case (tx_state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    tx_load       = 1'b1;
                    tx_beat_next  = '0;
                    tx_state_next = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                pin_out       = tx_shift[int'(tx_beat)*OUT_W +: OUT_W];
                pin_out_valid = 1'b1;
                if (tx_last) begin
                    tx_ready     = 1'b1;
                    tx_beat_next = '0;
                    if (tx_valid) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    tx_beat_next = tx_beat + TX_CW'(1);
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state <= TX_IDLE;
            tx_beat  <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_next;
            tx_beat  <= tx_beat_next;
            if (tx_load) begin
                tx_shift <= tx_word;
            end
        end
    end

    for (genvar i = 0; i < NUM_EF; i++) begin : g_ef
        avalon_ef_sync u_ef_sync (
            .CLK      (CLK),
            .RST      (RST),
            .ef_in    (ef_in[i]),
            .ef_clr   (ef_clr[i]),
            .ef_level (ef_level[i]),
            .ef_rise  (ef_rise[i])
        );
    end

endmodule

// File: tb/tb_avalon_pin_io.sv
// Scoreboard bench for avalon_pin_io: default-width instance plus a single-beat
// WORD_W=4 instance; consumed RX words and TX beats are checked against queued expectations.
module tb_avalon_pin_io;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;

    logic [3:0] pin_in = '0;
    logic       pin_strobe = 1'b0;
    logic [7:0] rx_word;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       ovr_clr = 1'b0;
    logic [7:0] tx_word = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [3:0] pin_out;
    logic       pin_out_valid;
    logic [1:0] ef_in = '0;
    logic [1:0] ef_level;
    logic [1:0] ef_rise;
    logic [1:0] ef_clr = '0;

    logic [3:0] pin_in4 = '0;
    logic       pin_strobe4 = 1'b0;
    logic [3:0] rx_word4;
    logic       rx_valid4;
    logic       rx_ready4 = 1'b0;
    logic       rx_overrun4;
    logic [3:0] tx_word4 = '0;
    logic       tx_ready4;
    logic [3:0] pin_out4;
    logic       pin_out_valid4;
    logic [1:0] ef_level4;
    logic [1:0] ef_rise4;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_exp[$];
    logic [3:0] tx_exp[$];
    logic [3:0] rx4_exp[$];

    always #5 CLK = ~CLK;

    avalon_pin_io #(.PIN_W(4), .WORD_W(8), .OUT_W(4), .NUM_EF(2)) dut (
        .CLK(CLK), .RST(RST),
        .pin_in(pin_in), .pin_strobe(pin_strobe),
        .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
        .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .pin_out(pin_out), .pin_out_valid(pin_out_valid),
        .ef_in(ef_in), .ef_level(ef_level), .ef_rise(ef_rise), .ef_clr(ef_clr)
    );

    avalon_pin_io #(.PIN_W(4), .WORD_W(4), .OUT_W(4), .NUM_EF(2)) dut4 (
        .CLK(CLK), .RST(RST),
        .pin_in(pin_in4), .pin_strobe(pin_strobe4),
        .rx_word(rx_word4), .rx_valid(rx_valid4), .rx_ready(rx_ready4),
        .rx_overrun(rx_overrun4), .ovr_clr(1'b0),
        .tx_word(tx_word4), .tx_valid(1'b0), .tx_ready(tx_ready4),
        .pin_out(pin_out4), .pin_out_valid(pin_out_valid4),
        .ef_in(2'b00), .ef_level(ef_level4), .ef_rise(ef_rise4), .ef_clr(2'b00)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] beat);
        pin_in     = beat;
        pin_strobe = 1'b1;
        tick();
        pin_strobe = 1'b0;
        pin_in     = '0;
    endtask

    // Monitor: pops an expectation whenever the DUT hands over a word or drives a beat
    always @(negedge CLK) begin
        if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rx_unexpected_word: got 0x%0h, expected no word", rx_word);
            end else begin
                checkOutput("rx_word_consumed", {24'd0, rx_word}, {24'd0, rx_exp.pop_front()});
            end
        end
        if (pin_out_valid) begin
            if (tx_exp.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL tx_unexpected_beat: got 0x%0h, expected no beat", pin_out);
            end else begin
                checkOutput("pin_out_beat", {28'd0, pin_out}, {28'd0, tx_exp.pop_front()});
            end
        end else begin
            checkOutput("pin_out_idle_zero", {28'd0, pin_out}, 32'd0);
        end
        if (rx_valid4 && rx_ready4) begin
            if (rx4_exp.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rx4_unexpected_word: got 0x%0h, expected no word", rx_word4);
            end else begin
                checkOutput("rx4_word_consumed", {28'd0, rx_word4}, {28'd0, rx4_exp.pop_front()});
            end
        end
    end

    initial begin
        // Reset values
        tick();
        tick();
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_rx_word", rx_word, 8'h00);
        checkOutput("reset_rx_overrun", rx_overrun, 1'b0);
        checkOutput("reset_pin_out_valid", pin_out_valid, 1'b0);
        checkOutput("reset_tx_ready", tx_ready, 1'b1);
        checkOutput("reset_ef_level", ef_level, 2'b00);
        checkOutput("reset_ef_rise", ef_rise, 2'b00);
        RST = 1'b1;
        tick();

        // Two beats assemble 0xA5, holder visible the cycle after the last beat
        applyStimulus(4'h5);
        checkOutput("rx_valid_after_first_beat", rx_valid, 1'b0);
        applyStimulus(4'hA);
        checkOutput("rx_valid_after_word", rx_valid, 1'b1);
        checkOutput("rx_word_a5", rx_word, 8'hA5);
        checkOutput("rx_overrun_clean", rx_overrun, 1'b0);

        // Holder full and not consumed: new word dropped, overrun set then cleared
        applyStimulus(4'h3);
        applyStimulus(4'hC);
        checkOutput("rx_word_kept_on_overrun", rx_word, 8'hA5);
        checkOutput("rx_overrun_set", rx_overrun, 1'b1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checkOutput("rx_overrun_cleared", rx_overrun, 1'b0);

        // Consume in the same cycle as the completing beat of 0x7E
        rx_exp.push_back(8'hA5);
        applyStimulus(4'hE);
        rx_ready = 1'b1;
        applyStimulus(4'h7);
        rx_exp.push_back(8'h7E);
        checkOutput("rx_word_7e", rx_word, 8'h7E);
        checkOutput("rx_valid_7e", rx_valid, 1'b1);
        checkOutput("rx_no_overrun_on_consume", rx_overrun, 1'b0);
        tick();
        rx_ready = 1'b0;
        checkOutput("rx_valid_cleared_by_take", rx_valid, 1'b0);

        // Gapless TX streaming of 0x3C then 0x96
        tx_exp.push_back(4'hC);
        tx_exp.push_back(4'h3);
        tx_exp.push_back(4'h6);
        tx_exp.push_back(4'h9);
        tx_word  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_word = 8'h96;
        checkOutput("tx_beat0_valid", pin_out_valid, 1'b1);
        checkOutput("tx_beat0_ready", tx_ready, 1'b0);
        tick();
        checkOutput("tx_beat1_valid", pin_out_valid, 1'b1);
        checkOutput("tx_last_beat_ready", tx_ready, 1'b1);
        tick();
        tx_valid = 1'b0;
        tx_word  = 8'h00;
        checkOutput("tx_beat2_valid", pin_out_valid, 1'b1);
        checkOutput("tx_beat2_ready", tx_ready, 1'b0);
        tick();
        checkOutput("tx_beat3_valid", pin_out_valid, 1'b1);
        tick();
        checkOutput("tx_idle_valid", pin_out_valid, 1'b0);
        checkOutput("tx_idle_pin_out", pin_out, 4'h0);
        checkOutput("tx_idle_ready", tx_ready, 1'b1);
        checkOutput("tx_queue_drained", tx_exp.size(), 0);

        // EF latency, then clear racing a fresh edge
        ef_in[1] = 1'b1;
        tick();
        checkOutput("ef_level_edge_k", ef_level[1], 1'b0);
        tick();
        checkOutput("ef_level_edge_k1", ef_level[1], 1'b1);
        checkOutput("ef_rise_edge_k1", ef_rise[1], 1'b0);
        tick();
        checkOutput("ef_rise_edge_k2", ef_rise[1], 1'b1);
        checkOutput("ef_flag0_quiet", {ef_level[0], ef_rise[0]}, 2'b00);
        ef_in[1] = 1'b0;
        tick();
        tick();
        tick();
        ef_clr[1] = 1'b1;
        tick();
        ef_clr[1] = 1'b0;
        checkOutput("ef_rise_cleared", ef_rise[1], 1'b0);
        checkOutput("ef_level_low", ef_level[1], 1'b0);
        ef_in[1] = 1'b1;
        tick();
        tick();
        ef_clr[1] = 1'b1;
        tick();
        ef_clr[1] = 1'b0;
        checkOutput("ef_rise_set_wins", ef_rise[1], 1'b1);

        // Reset mid-word discards the partial beat
        applyStimulus(4'hF);
        RST = 1'b0;
        #1;
        checkOutput("midreset_rx_valid", rx_valid, 1'b0);
        checkOutput("midreset_ef_rise", ef_rise, 2'b00);
        tick();
        RST = 1'b1;
        tick();
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        checkOutput("post_reset_rx_word", rx_word, 8'h21);
        checkOutput("post_reset_rx_valid", rx_valid, 1'b1);
        rx_exp.push_back(8'h21);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;

        // Single-beat word on the WORD_W=4 instance
        pin_in4     = 4'h9;
        pin_strobe4 = 1'b1;
        tick();
        pin_strobe4 = 1'b0;
        pin_in4     = 4'h0;
        checkOutput("rx4_word", rx_word4, 4'h9);
        checkOutput("rx4_valid", rx_valid4, 1'b1);
        rx4_exp.push_back(4'h9);
        rx_ready4 = 1'b1;
        tick();
        rx_ready4 = 1'b0;
        checkOutput("rx4_valid_cleared", rx_valid4, 1'b0);

        tick();
        checkOutput("rx_queue_drained", rx_exp.size(), 0);
        checkOutput("rx4_queue_drained", rx4_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
